// File: rtl/nibble_serial_add_seq_pkg.sv
// ============================================================================
// Module   : nsa_pkg
// Brief    : Shared types and constants for the nibble-serial add sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nsa_pkg;

  // Width of the external adder slice (one 74283 chip)
  localparam int NIBBLE_W = 4;

  // Sequencer states: waiting for a request, stepping nibbles, holding result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } nsa_state_e;

endpackage

`default_nettype wire

// File: rtl/nibble_serial_add_seq_shreg.sv
// ============================================================================
// Module   : nsa_nibble_shreg
// Brief    : WIDTH-bit register with parallel load and a one-nibble right
//            shift; the vacated top nibble is filled from shift_in_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nsa_nibble_shreg
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_data_i,
  input  logic                shift_i,
  input  logic [NIBBLE_W-1:0] shift_in_i,
  output logic [WIDTH-1:0]    data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load has priority over shift; otherwise hold
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {shift_in_i, data_q[WIDTH-1:NIBBLE_W]};
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_seq.sv
// ============================================================================
// Module   : nibble_serial_add_seq
// Brief    : WIDTH-bit adder built by time-multiplexing one external 4-bit
//            adder slice, LS nibble first, with a carry flip-flop between
//            nibbles. Optional macro NSA_SUB_EN adds a req_sub port that
//            turns the operation into A - B (B inverted, carry-in forced 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_add_seq
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH-1:0]    req_a,
  input  logic [WIDTH-1:0]    req_b,
  input  logic                req_ci,
`ifdef NSA_SUB_EN
  input  logic                req_sub,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_sum,
  output logic                rsp_co,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_ci,
  input  logic [NIBBLE_W-1:0] add_s,
  input  logic                add_co
);

  localparam int N        = WIDTH / NIBBLE_W;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Reject widths the nibble sequencing cannot handle
  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_add_seq: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  nsa_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic             accept;
  logic             run;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] b_load;
  logic             ci_load;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign run    = (state_q == ST_RUN);

`ifdef NSA_SUB_EN
  // Subtraction is A + ~B + 1; the caller's carry-in is ignored in that case
  assign b_load  = req_sub ? ~req_b : req_b;
  assign ci_load = req_sub ? 1'b1 : req_ci;
`else
  assign b_load  = req_b;
  assign ci_load = req_ci;
`endif

  // Next-state, nibble counter and inter-nibble carry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          carry_d = ci_load;
        end
      end
      ST_RUN: begin
        carry_d = add_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  nsa_nibble_shreg #(.WIDTH(WIDTH)) u_a_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i (req_a),
    .shift_i     (run),
    .shift_in_i  ({NIBBLE_W{1'b0}}),
    .data_o      (a_q)
  );

  nsa_nibble_shreg #(.WIDTH(WIDTH)) u_b_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i (b_load),
    .shift_i     (run),
    .shift_in_i  ({NIBBLE_W{1'b0}}),
    .data_o      (b_q)
  );

  // Sum nibbles enter at the top, so after N shifts the LS nibble is at bit 0
  nsa_nibble_shreg #(.WIDTH(WIDTH)) u_sum_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i ({WIDTH{1'b0}}),
    .shift_i     (run),
    .shift_in_i  (add_s),
    .data_o      (sum_q)
  );

  // Upper operand bits only feed the shift chain, never the adder directly
  logic unused_upper;
  assign unused_upper = ^{a_q[WIDTH-1:NIBBLE_W], b_q[WIDTH-1:NIBBLE_W]};

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_sum   = rsp_valid ? sum_q : '0;
  assign rsp_co    = rsp_valid ? carry_q : 1'b0;

  // The shared adder sees quiet zeros whenever this block is not using it
  assign add_a  = run ? a_q[NIBBLE_W-1:0] : '0;
  assign add_b  = run ? b_q[NIBBLE_W-1:0] : '0;
  assign add_ci = run ? carry_q : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_seq.sv
// ============================================================================
// Module   : tb_nibble_serial_add_seq
// Brief    : Self-checking bench for nibble_serial_add_seq with a behavioural
//            74283 slice; honours NSA_SUB_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_add_seq;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_ci;
`ifdef NSA_SUB_EN
  logic             req_sub;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_co;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_ci;
  logic [3:0]       add_s;
  logic             add_co;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0]   sb[$];
  logic [WIDTH-1:0] cur_a;

  nibble_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
`ifdef NSA_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  // Behavioural 4-bit adder slice
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected {co,sum}, return #1 after accept
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic sub);
    logic [WIDTH-1:0] bb;
    logic             cc;
    int               n;
    bb = sub ? ~b : b;
    cc = sub ? 1'b1 : ci;
    sb.push_back({1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc});
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_ci    = ci;
`ifdef NSA_SUB_EN
    req_sub   = sub;
`endif
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cur_a     = a;
  endtask

  // Wait for the response, check latency, nibble order, backpressure, result
  task automatic recv(input int bp);
    int             lat;
    logic [WIDTH:0] exp;
    lat = 0;
    check("nibble_a0", {28'd0, add_a}, {28'd0, cur_a[3:0]});
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (!rsp_valid && lat < N) check("nibble_a", {28'd0, add_a}, {28'd0, cur_a[4*lat +: 4]});
    end
    check("latency", lat, N);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("hold_sum", {16'd0, rsp_sum}, {16'd0, exp[WIDTH-1:0]});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("idle_add", {23'd0, add_a, add_b, add_ci}, 32'd0);
    end
    check("rsp_sum", {16'd0, rsp_sum}, {16'd0, exp[WIDTH-1:0]});
    check("rsp_co", {31'd0, rsp_co}, {31'd0, exp[WIDTH]});
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("after_req_ready", {31'd0, req_ready}, 32'd1);
    check("after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("after_idle_add", {23'd0, add_a, add_b, add_ci}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_sum"}, {16'd0, rsp_sum}, 32'd0);
    check({tag, "_rsp_co"}, {31'd0, rsp_co}, 32'd0);
    check({tag, "_add"}, {23'd0, add_a, add_b, add_ci}, 32'd0);
  endtask

  initial begin
    logic sub_r;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_ci    = 1'b0;
`ifdef NSA_SUB_EN
    req_sub   = 1'b0;
`endif
    rsp_ready = 1'b0;
    cur_a     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    recv(0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    recv(1);
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    recv(3);

    // Abort an operation two RUN cycles in with an asynchronous reset
    @(negedge clk);
    req_a     = 16'hAAAA;
    req_b     = 16'h5555;
    req_ci    = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("post_reset");

    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    recv(0);

`ifdef NSA_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    recv(0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1);
    recv(2);
`endif

    for (int i = 0; i < 1000; i++) begin
`ifdef NSA_SUB_EN
      sub_r = 1'($urandom_range(0, 1));
`else
      sub_r = 1'b0;
`endif
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), sub_r);
      recv(int'($urandom_range(0, 3)));
    end

    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
